// File: rtl/div_result_bcd.sv
// div_result_bcd
// Sequential binary-to-BCD converter placed after the array divider.
// Accepts one quotient/remainder pair over a valid/ready handshake, converts
// both values in parallel with shift-and-add-3 (one bit per clock) and holds
// the packed BCD results on a registered valid/ready output.
//
// Optional feature macro: DIV_BCD_LEADING_BLANK_EN
//   When defined, leading zero digits above the most significant nonzero digit
//   are replaced with 4'hF (blank code). Digit 0 is never blanked.
//
// Ports:
//   clk        clock, all state updates on rising edge
//   rst        synchronous active-high reset
//   in_valid   Q/R valid this cycle
//   in_ready   block can accept a pair (registered)
//   Q, R       unsigned quotient / remainder, width bits
//   out_valid  Q_bcd/R_bcd hold a finished result (registered)
//   out_ready  consumer takes the result
//   Q_bcd      packed BCD of captured Q, digit 0 in [3:0]
//   R_bcd      packed BCD of captured R, digit 0 in [3:0]
module div_result_bcd #(
  parameter int unsigned width = 4,
  localparam int unsigned DIGITS = (width + 2) / 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [width-1:0]      Q,
  input  logic [width-1:0]      R,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   Q_bcd,
  output logic [4*DIGITS-1:0]   R_bcd
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(width + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [width-1:0]  q_sr, r_sr;
  logic [BW-1:0]     q_acc, r_acc;
  logic [CW-1:0]     cnt;
  logic              accept, last;

  logic [BW-1:0]       q_adj, r_adj;
  logic [BW+width-1:0] q_cat, r_cat;
  logic [BW-1:0]       q_res, r_res;

  // Add 3 to every digit that is 5 or more; no carry between digits.
  function automatic logic [BW-1:0] adj3(input logic [BW-1:0] v);
    logic [3:0] d;
    adj3 = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = v[4*i +: 4];
      if (d >= 4'd5) adj3[4*i +: 4] = d + 4'd3;
    end
  endfunction

`ifdef DIV_BCD_LEADING_BLANK_EN
  // Replace leading zero digits with the blank code, keeping digit 0.
  function automatic logic [BW-1:0] blank(input logic [BW-1:0] v);
    logic lead;
    lead  = 1'b1;
    blank = v;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (lead && (v[4*i +: 4] == 4'd0)) blank[4*i +: 4] = 4'hF;
      else                               lead = 1'b0;
    end
  endfunction
`endif

  // Next-state and control decode
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CW'(width - 1)) begin
          last    = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
    end
  end

  // One double-dabble step: adjust then shift {accumulator, binary} left
  always_comb begin
    q_adj = adj3(q_acc);
    r_adj = adj3(r_acc);
    q_cat = {q_adj, q_sr} << 1;
    r_cat = {r_adj, r_sr} << 1;
`ifdef DIV_BCD_LEADING_BLANK_EN
    q_res = blank(q_cat[BW+width-1:width]);
    r_res = blank(r_cat[BW+width-1:width]);
`else
    q_res = q_cat[BW+width-1:width];
    r_res = r_cat[BW+width-1:width];
`endif
  end

  // Conversion datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      q_sr  <= '0;
      r_sr  <= '0;
      q_acc <= '0;
      r_acc <= '0;
      cnt   <= '0;
      Q_bcd <= '0;
      R_bcd <= '0;
    end else if (accept) begin
      q_sr  <= Q;
      r_sr  <= R;
      q_acc <= '0;
      r_acc <= '0;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      q_sr  <= q_cat[width-1:0];
      r_sr  <= r_cat[width-1:0];
      q_acc <= q_cat[BW+width-1:width];
      r_acc <= r_cat[BW+width-1:width];
      cnt   <= cnt + CW'(1);
      if (last) begin
        Q_bcd <= q_res;
        R_bcd <= r_res;
      end
    end
  end

endmodule

// File: tb/tb_div_result_bcd.sv
// Testbench for div_result_bcd: width=4 and width=8 instances checked against
// a decimal-arithmetic model (honours DIV_BCD_LEADING_BLANK_EN if defined).
module tb_div_result_bcd;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       v4, rdy4, ov4, or4;
  logic [3:0] q4, r4;
  logic [7:0] qb4, rb4;

  logic        v8, rdy8, ov8, or8;
  logic [7:0]  q8, r8;
  logic [11:0] qb8, rb8;

  int n_checks = 0;
  int n_fail   = 0;

  div_result_bcd #(.width(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .Q(q4), .R(r4),
    .out_valid(ov4), .out_ready(or4), .Q_bcd(qb4), .R_bcd(rb4)
  );

  div_result_bcd #(.width(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .Q(q8), .R(r8),
    .out_valid(ov8), .out_ready(or8), .Q_bcd(qb8), .R_bcd(rb8)
  );

  // Decimal digits by division; leading digits blank when the value is below 10^i.
  function automatic logic [11:0] bcd_model(input int unsigned v, input int unsigned digits);
    int unsigned p;
    logic [11:0] res;
    p   = 1;
    res = '0;
    for (int unsigned i = 0; i < digits; i++) begin
      res[4*i +: 4] = 4'((v / p) % 10);
`ifdef DIV_BCD_LEADING_BLANK_EN
      if (i > 0 && v < p) res[4*i +: 4] = 4'hF;
`endif
      p = p * 10;
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready4 got=%b exp=1", rdy4); end
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid4 got=%b exp=0", ov4); end
    n_checks++; if (qb4 !== 8'h00 || rb4 !== 8'h00) begin n_fail++; $display("FAIL reset_bcd4 got=%h/%h exp=00/00", qb4, rb4); end
    n_checks++; if (rdy8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready8 got=%b exp=1", rdy8); end
    n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid8 got=%b exp=0", ov8); end
    n_checks++; if (qb8 !== 12'h000 || rb8 !== 12'h000) begin n_fail++; $display("FAIL reset_bcd8 got=%h/%h exp=000/000", qb8, rb8); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_w4_basic();
    int n;
    logic [11:0] eq, er;
    eq = bcd_model(15, 2);
    er = bcd_model(9, 2);
    q4 = 4'd15; r4 = 4'd9; v4 = 1'b1;
    tick();
    v4 = 1'b0; q4 = 4'd3; r4 = 4'd2;
    n = 0;
    while (n < 20 && ov4 !== 1'b1) begin tick(); n++; end
    n_checks++; if (n != 4) begin n_fail++; $display("FAIL w4_latency got=%0d exp=4", n); end
    n_checks++; if (qb4 !== eq[7:0]) begin n_fail++; $display("FAIL w4_q_bcd got=%h exp=%h", qb4, eq[7:0]); end
    n_checks++; if (rb4 !== er[7:0]) begin n_fail++; $display("FAIL w4_r_bcd got=%h exp=%h", rb4, er[7:0]); end
    n_checks++; if (rdy4 !== 1'b0) begin n_fail++; $display("FAIL w4_in_ready_done got=%b exp=0", rdy4); end
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
    n_checks++; if (ov4 !== 1'b0 || rdy4 !== 1'b1) begin n_fail++; $display("FAIL w4_release got ov=%b rdy=%b exp ov=0 rdy=1", ov4, rdy4); end
  endtask

  task automatic test_w8_values();
    int unsigned qs[4];
    int unsigned rs[4];
    int n;
    logic [11:0] eq, er;
    qs[0] = 255; rs[0] = 0;
    qs[1] = 7;   rs[1] = 0;
    qs[2] = $urandom_range(0, 255); rs[2] = $urandom_range(0, 255);
    qs[3] = 0;   rs[3] = 100;
    for (int k = 0; k < 4; k++) begin
      eq = bcd_model(qs[k], 3);
      er = bcd_model(rs[k], 3);
      q8 = 8'(qs[k]); r8 = 8'(rs[k]); v8 = 1'b1;
      tick();
      v8 = 1'b0; q8 = 8'($urandom); r8 = 8'($urandom);
      n = 0;
      while (n < 30 && ov8 !== 1'b1) begin tick(); n++; end
      n_checks++; if (n != 8) begin n_fail++; $display("FAIL w8_latency[%0d] got=%0d exp=8", k, n); end
      n_checks++; if (qb8 !== eq) begin n_fail++; $display("FAIL w8_q_bcd[%0d] q=%0d got=%h exp=%h", k, qs[k], qb8, eq); end
      n_checks++; if (rb8 !== er) begin n_fail++; $display("FAIL w8_r_bcd[%0d] r=%0d got=%h exp=%h", k, rs[k], rb8, er); end
      or8 = 1'b1;
      tick();
      or8 = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int n, seen;
    logic [11:0] eq, er;
    eq = bcd_model(123, 3);
    er = bcd_model(45, 3);
    q8 = 8'd123; r8 = 8'd45; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    n = 0;
    while (n < 30 && ov8 !== 1'b1) begin tick(); n++; end
    n_checks++; if (n != 8) begin n_fail++; $display("FAIL bp_latency got=%0d exp=8", n); end
    for (int c = 0; c < 6; c++) begin
      q8 = 8'($urandom); r8 = 8'($urandom); v8 = ~v8;
      tick();
      n_checks++;
      if (ov8 !== 1'b1 || rdy8 !== 1'b0 || qb8 !== eq || rb8 !== er) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got ov=%b rdy=%b q=%h r=%h exp ov=1 rdy=0 q=%h r=%h", c, ov8, rdy8, qb8, rb8, eq, er);
      end
    end
    v8 = 1'b0;
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    n_checks++; if (ov8 !== 1'b0 || rdy8 !== 1'b1) begin n_fail++; $display("FAIL bp_release got ov=%b rdy=%b exp ov=0 rdy=1", ov8, rdy8); end
    seen = 0;
    for (int c = 0; c < 15; c++) begin tick(); if (ov8 === 1'b1) seen++; end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL bp_no_second got=%0d results exp=0", seen); end
  endtask

  task automatic test_reset_mid();
    int seen;
    q8 = 8'd200; r8 = 8'd17; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (ov8 !== 1'b0 || rdy8 !== 1'b1) begin n_fail++; $display("FAIL rmid_ctrl got ov=%b rdy=%b exp ov=0 rdy=1", ov8, rdy8); end
    n_checks++; if (qb8 !== 12'h000 || rb8 !== 12'h000) begin n_fail++; $display("FAIL rmid_bcd got=%h/%h exp=000/000", qb8, rb8); end
    seen = 0;
    for (int c = 0; c < 20; c++) begin tick(); if (ov8 === 1'b1) seen++; end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rmid_no_result got=%0d results exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_q[$];
    logic [11:0] exp_r[$];
    logic [11:0] eq, er;
    int unsigned qv, rv;
    int sent, got, last_t, t;
    sent = 0; got = 0; last_t = -1; t = 0;
    or8 = 1'b1;
    while (t < 1200 && got < 100) begin
      if (ov8 === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b2b_extra got=%h/%h exp=none", qb8, rb8);
        end else begin
          eq = exp_q.pop_front();
          er = exp_r.pop_front();
          n_checks++;
          if (qb8 !== eq || rb8 !== er) begin
            n_fail++;
            $display("FAIL b2b_data[%0d] got=%h/%h exp=%h/%h", got, qb8, rb8, eq, er);
          end
        end
        if (last_t >= 0) begin
          n_checks++;
          if (t - last_t != 10) begin n_fail++; $display("FAIL b2b_period[%0d] got=%0d exp=10", got, t - last_t); end
        end
        last_t = t;
        got++;
      end
      if (rdy8 === 1'b1 && sent < 100) begin
        qv = $urandom_range(0, 255);
        rv = $urandom_range(0, 255);
        q8 = 8'(qv); r8 = 8'(rv); v8 = 1'b1;
        exp_q.push_back(bcd_model(qv, 3));
        exp_r.push_back(bcd_model(rv, 3));
        sent++;
      end else begin
        v8 = 1'b0;
      end
      if (got < 100) begin tick(); t++; end
    end
    v8 = 1'b0;
    or8 = 1'b0;
    n_checks++; if (got != 100) begin n_fail++; $display("FAIL b2b_count got=%0d exp=100", got); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_pending got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1;
    v4 = 1'b0; or4 = 1'b0; q4 = '0; r4 = '0;
    v8 = 1'b0; or8 = 1'b0; q8 = '0; r8 = '0;
    test_reset();
    test_w4_basic();
    test_w8_values();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_result_bcd.md
# div_result_bcd

Sequential binary-to-BCD converter sitting directly downstream of the combinational array divider. It accepts one quotient/remainder pair per transaction over a valid/ready handshake. It converts both values to packed BCD in parallel using shift-and-add-3 (double dabble), one bit per clock. The result is presented on a registered valid/ready output, typically for display or logging logic.

## Interface
Parameters:
- `width`, default 4: bit width of `Q` and `R`; matches the divider's `width`; legal range 2..32.
- `DIGITS`, default `(width+2)/3`: BCD digits per output; derived, not overridden.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: `Q`/`R` are valid this cycle.
- `in_ready`  out  1: block can accept a pair.
- `Q`  in  `width`: unsigned quotient from the divider.
- `R`  in  `width`: unsigned remainder from the divider.
- `out_valid`  out  1: `Q_bcd`/`R_bcd` hold a finished result.
- `out_ready`  in  1: consumer takes the result.
- `Q_bcd`  out  `4*DIGITS`: packed BCD of the captured `Q`; digit 0 is in bits [3:0].
- `R_bcd`  out  `4*DIGITS`: packed BCD of the captured `R`; digit 0 is in bits [3:0].

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready=1`.
  - On `in_valid&&in_ready`: capture `Q` and `R` into shift registers, clear both BCD accumulators, clear bit counter, go to SHIFT.
- SHIFT:
  - `in_ready=0`.
  - Each cycle, for both accumulators: every BCD digit ≥5 gets +3, then shift {accumulator, binary} left by 1 and increment counter.
  - After the `width`-th shift, copy the accumulators to `Q_bcd`/`R_bcd` and go to DONE.
- DONE:
  - `out_valid=1`.
  - `Q_bcd`/`R_bcd` are stable.
  - On `out_ready`: go to IDLE and clear `out_valid`.
- `in_valid` while not in IDLE is ignored; the value is not queued and there is no side effect.
- `Q`/`R` are sampled only on the accepting edge. Later changes do not affect the result.
- Input value 0 still takes the full `width` shifts and yields all-zero digits.
- Arithmetic:
  - Digit adjust is 4-bit, with no carry between digits except through the shift.
  - Unused upper digits stay 0.
  - No overflow is possible, since `DIGITS` covers 2^`width`−1.

## Timing
- Reset values:
  - `in_ready=1`, `out_valid=0`, `Q_bcd=0`, `R_bcd=0`.
  - FSM=IDLE, counter=0.
- Latency: accepting edge E0 → `out_valid` high after edge E`width`, i.e. `width` clocks later.
- Holding `out_valid=1` needs no `out_ready`; the result is held indefinitely.
- Result removal:
  - Edge with `out_valid&&out_ready`: `out_valid` falls after that edge and `in_ready` rises.
  - A new accept is possible on the next edge.
  - Throughput is one pair per `width+2` clocks at best.
- `out_ready` high before `out_valid` is harmless; the handshake completes on the first edge where both are high.
- `rst` asserted in any state, including mid-SHIFT or DONE:
  - The next edge forces reset values.
  - The in-flight result is discarded and `out_valid` is never raised for it.
- `rst` wins over a simultaneous accept or out handshake.

## Configuration
- `DIV_BCD_LEADING_BLANK_EN` defined:
  - When loading `Q_bcd`/`R_bcd` in the SHIFT→DONE transition, each leading zero digit above the first nonzero digit is replaced with 4'hF (blank code).
  - Digit 0 is never blanked, so value 0 gives …F0.
- Not defined: plain BCD, leading zeros kept.
- Latency is identical either way.

## Test plan
- `width`=4:
  - Stimulus: accept `Q`=15, `R`=9.
  - Required: `out_valid` exactly 4 clocks after the accept, `Q_bcd`=8'h15, `R_bcd`=8'h09; after `out_ready`, `in_ready`=1 next cycle.
- `width`=8:
  - Stimulus: `Q`=255, `R`=0.
  - Required: `Q_bcd`=12'h255, `R_bcd`=12'h000.
  - With `DIV_BCD_LEADING_BLANK_EN`, `Q`=7 → `Q_bcd`=12'hFF7, `R_bcd`=12'hFF0.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 6 cycles after `out_valid`, and toggle `Q`/`R` plus pulse `in_valid` meanwhile.
  - Required: outputs stable, `in_ready`=0, second pair not accepted; release gives exactly one result.
- Reset mid-operation:
  - Stimulus: assert `rst` 2 clocks into SHIFT for `width`=8, `Q`=200.
  - Required: next cycle `out_valid`=0, `in_ready`=1, `Q_bcd`=0; no result ever appears for `Q`=200.
- Back-to-back with `out_ready` tied 1:
  - Stimulus: 100 random pairs with `width`=8.
  - Required: each BCD matches the decimal model, one result per 10 clocks, no drops or duplicates.
